// File: rtl/eth_pkg.sv
// Shared Ethernet receive/transmit definitions.
// Holds the CRC-32 constants, default frame length limits, the broadcast
// address and the receive state encoding used by eth_rx_fcs_chk.
package eth_pkg;

  // Reflected CRC-32 (IEEE 802.3).
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Register value left after running the CRC over data plus a correct FCS.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // Frame length limits, destination address through FCS inclusive.
  localparam int MIN_LEN_DEF = 64;
  localparam int MAX_LEN_DEF = 1518;

  // Frame length counter ceiling (11-bit counter).
  localparam logic [10:0] LEN_SAT = 11'h7FF;

  localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  typedef struct packed {
    logic crc;
    logic runt;
    logic giant;
    logic abort;
    logic addr;
  } errFlags_t;

endpackage

// File: rtl/eth_rx_fcs_chk_if.sv
// Receive byte stream and frame status bundle for eth_rx_fcs_chk.
//   Byte_In / Byte_In_Vld / Byte_In_Sof / Byte_In_Eof : inbound stream
//   Byte_Out / Byte_Out_Vld / Byte_Out_Sof / Byte_Out_Eof : one-cycle delayed copy
//   Frame_Done, Frame_Good, Err_* , Frame_Len : per-frame status
//   Cnt_Good / Cnt_Bad : saturating frame statistics
// master: the side that sources bytes and consumes status.
// slave : the checker.
interface eth_rx_fcs_chk_if;
  logic [7:0]  Byte_In;
  logic        Byte_In_Vld;
  logic        Byte_In_Sof;
  logic        Byte_In_Eof;

  logic [7:0]  Byte_Out;
  logic        Byte_Out_Vld;
  logic        Byte_Out_Sof;
  logic        Byte_Out_Eof;

  logic        Frame_Done;
  logic        Frame_Good;
  logic        Err_Crc;
  logic        Err_Runt;
  logic        Err_Giant;
  logic        Err_Abort;
  logic        Err_Addr;
  logic [10:0] Frame_Len;
  logic [15:0] Cnt_Good;
  logic [15:0] Cnt_Bad;

  modport master (
    output Byte_In, Byte_In_Vld, Byte_In_Sof, Byte_In_Eof,
    input  Byte_Out, Byte_Out_Vld, Byte_Out_Sof, Byte_Out_Eof,
    input  Frame_Done, Frame_Good, Err_Crc, Err_Runt, Err_Giant, Err_Abort,
           Err_Addr, Frame_Len, Cnt_Good, Cnt_Bad
  );

  modport slave (
    input  Byte_In, Byte_In_Vld, Byte_In_Sof, Byte_In_Eof,
    output Byte_Out, Byte_Out_Vld, Byte_Out_Sof, Byte_Out_Eof,
    output Frame_Done, Frame_Good, Err_Crc, Err_Runt, Err_Giant, Err_Abort,
           Err_Addr, Frame_Len, Cnt_Good, Cnt_Bad
  );
endinterface

// File: rtl/eth_crc32_byte.sv
// Combinational single-byte step of the reflected Ethernet CRC-32.
//   CrcIn  : current CRC register
//   DataIn : byte, first-transmitted bit in bit 0
//   CrcOut : CRC register after absorbing DataIn
// Shared by the receive checker and the transmit FCS generator.
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] CrcIn,
  input  logic [7:0]  DataIn,
  output logic [31:0] CrcOut
);

  always_comb begin
    CrcOut = CrcIn;
    for (int i = 0; i < 8; i++) begin
      if (CrcOut[0] ^ DataIn[i])
        CrcOut = (CrcOut >> 1) ^ CRC_POLY;
      else
        CrcOut = CrcOut >> 1;
    end
  end

endmodule

// File: rtl/eth_rx_fcs_chk.sv
// Ethernet receive FCS / length checker.
// Consumes the byte stream from the RMII receive stage (first DA byte through
// last FCS byte), checks CRC-32 residue and length limits, forwards bytes with
// one cycle of latency and reports a one-cycle Frame_Done with held flags and
// saturating good/bad counters.
// Ports:
//   Clk : system clock (50 MHz RMII reference)
//   Rst : synchronous, active-high reset
//   Rx  : eth_rx_fcs_chk_if.slave (stream in, delayed stream out, status)
// Optional: define ETH_RX_ADDR_FILT_EN to build destination address filtering
// against pMAC_ADDR (broadcast also accepted); otherwise Err_Addr is 0.
module eth_rx_fcs_chk
  import eth_pkg::*;
#(
  parameter int          pMIN_LEN  = MIN_LEN_DEF,
  parameter int          pMAX_LEN  = MAX_LEN_DEF,
  parameter logic [47:0] pMAC_ADDR = 48'h02_00_00_00_00_01
) (
  input logic              Clk,
  input logic              Rst,
  eth_rx_fcs_chk_if.slave  Rx
);

  localparam logic [10:0] MIN_L = 11'(pMIN_LEN);
  localparam logic [10:0] MAX_L = 11'(pMAX_LEN);

  state_t      state;
  logic [31:0] crcReg, crcBase, crcNext;
  logic [10:0] lenReg, lenBase, lenNext;
  logic        vld, sof, eof;
  logic        abortFrame, endFrame, frameActive;
  logic        errAddrEnd, errAddrAbort;
  errFlags_t   st;
  logic [10:0] stLen;
  logic        stBad;

  // Registered outputs
  logic [7:0]  byteOut;
  logic        byteOutVld, byteOutSof, byteOutEof;
  logic        frameDone, frameGood;
  errFlags_t   errReg;
  logic [10:0] frameLen;
  logic [15:0] cntGood, cntBad;

  assign vld = Rx.Byte_In_Vld;
  assign sof = vld & Rx.Byte_In_Sof;
  assign eof = vld & Rx.Byte_In_Eof;

  // A Sof byte always reseeds, so the CRC and length start from that byte
  // whether we were idle or aborting a frame in progress.
  assign crcBase = sof ? CRC_INIT : crcReg;
  assign lenBase = sof ? 11'd0 : lenReg;
  assign lenNext = (lenBase == LEN_SAT) ? LEN_SAT : lenBase + 11'd1;

  eth_crc32_byte uCrc (
    .CrcIn  (crcBase),
    .DataIn (Rx.Byte_In),
    .CrcOut (crcNext)
  );

  assign frameActive = (state == FRAME) | sof;
  assign abortFrame  = sof & (state == FRAME);
  // Sof+Eof while a frame is open reports only the abort; the one-byte frame
  // that would follow is dropped since only one status can issue per cycle.
  assign endFrame    = eof & frameActive & ~abortFrame;

`ifdef ETH_RX_ADDR_FILT_EN
  logic        ucReg, bcReg, ucNext, bcNext;
  logic [47:0] macShift;

  // Track station and broadcast matches over DA bytes 0..5; lenBase is the
  // index of the current byte within the frame.
  always_comb begin
    ucNext   = sof ? 1'b1 : ucReg;
    bcNext   = sof ? 1'b1 : bcReg;
    macShift = pMAC_ADDR << {lenBase[2:0], 3'b000};
    if (lenBase < 11'd6) begin
      ucNext = ucNext & (Rx.Byte_In == macShift[47:40]);
      bcNext = bcNext & (Rx.Byte_In == BCAST_ADDR[7:0]);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ucReg <= 1'b0;
      bcReg <= 1'b0;
    end else if (vld && frameActive) begin
      ucReg <= ucNext;
      bcReg <= bcNext;
    end
  end

  // Frames too short to carry a whole DA count as address failures.
  assign errAddrEnd   = ~(ucNext | bcNext) | (lenNext < 11'd6);
  assign errAddrAbort = ~(ucReg | bcReg) | (lenReg < 11'd6);
`else
  logic unusedMacBits;
  assign unusedMacBits = ^pMAC_ADDR;
  assign errAddrEnd    = 1'b0;
  assign errAddrAbort  = 1'b0;
`endif

  // Abort reports the frame as it stood before the new Sof byte.
  always_comb begin
    if (abortFrame) begin
      st.crc   = (crcReg != CRC_RESIDUE);
      st.addr  = errAddrAbort;
      st.abort = 1'b1;
      stLen    = lenReg;
    end else begin
      st.crc   = (crcNext != CRC_RESIDUE);
      st.addr  = errAddrEnd;
      st.abort = 1'b0;
      stLen    = lenNext;
    end
    st.runt  = (stLen < MIN_L);
    st.giant = (stLen > MAX_L);
    stBad    = |st;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      crcReg     <= CRC_INIT;
      lenReg     <= '0;
      byteOut    <= '0;
      byteOutVld <= 1'b0;
      byteOutSof <= 1'b0;
      byteOutEof <= 1'b0;
      frameDone  <= 1'b0;
      frameGood  <= 1'b0;
      errReg     <= '0;
      frameLen   <= '0;
      cntGood    <= '0;
      cntBad     <= '0;
    end else begin
      byteOut    <= Rx.Byte_In;
      byteOutVld <= Rx.Byte_In_Vld;
      byteOutSof <= Rx.Byte_In_Sof;
      byteOutEof <= Rx.Byte_In_Eof;

      frameDone <= abortFrame | endFrame;
      if (abortFrame | endFrame) begin
        errReg    <= st;
        frameGood <= ~stBad;
        frameLen  <= stLen;
        if (stBad) begin
          if (cntBad != 16'hFFFF) cntBad <= cntBad + 16'd1;
        end else begin
          if (cntGood != 16'hFFFF) cntGood <= cntGood + 16'd1;
        end
      end

      if (vld) begin
        case (state)
          IDLE: begin
            if (sof) begin
              crcReg <= crcNext;
              lenReg <= lenNext;
              state  <= eof ? IDLE : FRAME;
            end
          end
          FRAME: begin
            crcReg <= crcNext;
            lenReg <= lenNext;
            if (eof) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign Rx.Byte_Out     = byteOut;
  assign Rx.Byte_Out_Vld = byteOutVld;
  assign Rx.Byte_Out_Sof = byteOutSof;
  assign Rx.Byte_Out_Eof = byteOutEof;
  assign Rx.Frame_Done   = frameDone;
  assign Rx.Frame_Good   = frameGood;
  assign Rx.Err_Crc      = errReg.crc;
  assign Rx.Err_Runt     = errReg.runt;
  assign Rx.Err_Giant    = errReg.giant;
  assign Rx.Err_Abort    = errReg.abort;
  assign Rx.Err_Addr     = errReg.addr;
  assign Rx.Frame_Len    = frameLen;
  assign Rx.Cnt_Good     = cntGood;
  assign Rx.Cnt_Bad      = cntBad;

endmodule

// File: tb/tb_eth_rx_fcs_chk.sv
// Scoreboard bench for eth_rx_fcs_chk: directed frames push expected status,
// a negedge monitor pops on Frame_Done and also checks the byte passthrough.
module tb_eth_rx_fcs_chk;
  import eth_pkg::*;

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
`ifdef ETH_RX_ADDR_FILT_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic [5:0]  flags;  // {good, crc, runt, giant, abort, addr}
    logic [10:0] len;
    logic [15:0] cg;
    logic [15:0] cb;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  eth_rx_fcs_chk_if rxIf();

  eth_rx_fcs_chk #(.pMIN_LEN(64), .pMAX_LEN(1518), .pMAC_ADDR(MAC)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .Rx  (rxIf.slave)
  );

  always #10 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mCg = 0;
  int mCb = 0;
  exp_t expQ[$];
  exp_t curE;
  logic [7:0] frm[$];
  logic [10:0] snap = '0;
  logic snapOk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crcOfFrm();
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (frm[k])
      for (int j = 0; j < 8; j++)
        c = (c[0] ^ frm[k][j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Frame of 'len' bytes: DA, fixed SA, payload pattern, correct FCS.
  task automatic build(input logic [47:0] da, input int len);
    logic [47:0] sa = 48'h02_00_00_00_00_AA;
    logic [31:0] fcs;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(sa[47-8*i -: 8]);
    for (int i = 12; i < len - 4; i++) frm.push_back(8'(i * 7 + 3));
    fcs = ~crcOfFrm();
    frm.push_back(fcs[7:0]);
    frm.push_back(fcs[15:8]);
    frm.push_back(fcs[23:16]);
    frm.push_back(fcs[31:24]);
  endtask

  function automatic exp_t mkExp(bit crc, bit runt, bit giant, bit abrt, bit addr, int len);
    exp_t e;
    e.cyc   = 0;
    e.flags = {~(crc | runt | giant | abrt | addr), crc, runt, giant, abrt, addr};
    e.len   = 11'(len);
    e.cg    = '0;
    e.cb    = '0;
    return e;
  endfunction

  // Called in the same timestep the triggering byte is driven.
  task automatic pushExp(input exp_t e);
    e.cyc = cyc + 1;
    if (e.flags[5]) mCg++; else mCb++;
    e.cg = 16'(mCg);
    e.cb = 16'(mCb);
    expQ.push_back(e);
  endtask

  task automatic driveByte(input logic [7:0] b, input bit s, input bit e);
    rxIf.Byte_In     = b;
    rxIf.Byte_In_Vld = 1'b1;
    rxIf.Byte_In_Sof = s;
    rxIf.Byte_In_Eof = e;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    rxIf.Byte_In_Vld = 1'b0;
    rxIf.Byte_In_Sof = 1'b0;
    rxIf.Byte_In_Eof = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic sendFrame(input int gap, input exp_t e, input bit withEof);
    for (int i = 0; i < frm.size(); i++) begin
      bit last = (i == frm.size() - 1) && withEof;
      if (last) pushExp(e);
      driveByte(frm[i], i == 0, last);
      repeat (gap) idle();
    end
    idle();
  endtask

  always @(posedge Clk) begin
    cyc    <= cyc + 1;
    snap   <= {rxIf.Byte_In, rxIf.Byte_In_Vld, rxIf.Byte_In_Sof, rxIf.Byte_In_Eof};
    snapOk <= !Rst;
  end

  always @(negedge Clk) begin
    if (!Rst) begin
      if (snapOk)
        chk("passthru",
            {rxIf.Byte_Out, rxIf.Byte_Out_Vld, rxIf.Byte_Out_Sof, rxIf.Byte_Out_Eof}, snap);
      if (rxIf.Frame_Done) begin
        if (expQ.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          curE = expQ.pop_front();
          chk("done_cycle", 64'(cyc), 64'(curE.cyc));
          chk("flags", {rxIf.Frame_Good, rxIf.Err_Crc, rxIf.Err_Runt, rxIf.Err_Giant,
                        rxIf.Err_Abort, rxIf.Err_Addr}, curE.flags);
          chk("frame_len", rxIf.Frame_Len, curE.len);
          chk("cnt_good", rxIf.Cnt_Good, curE.cg);
          chk("cnt_bad", rxIf.Cnt_Bad, curE.cb);
        end
      end
    end
  end

  initial begin
    rxIf.Byte_In     = 8'h00;
    rxIf.Byte_In_Vld = 1'b0;
    rxIf.Byte_In_Sof = 1'b0;
    rxIf.Byte_In_Eof = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_outputs",
        {rxIf.Byte_Out, rxIf.Byte_Out_Vld, rxIf.Byte_Out_Sof, rxIf.Byte_Out_Eof,
         rxIf.Frame_Done, rxIf.Frame_Good, rxIf.Err_Crc, rxIf.Err_Runt, rxIf.Err_Giant,
         rxIf.Err_Abort, rxIf.Err_Addr, rxIf.Frame_Len, rxIf.Cnt_Good, rxIf.Cnt_Bad}, 64'd0);
    @(posedge Clk);
    #1 Rst = 1'b0;
    idle();

    // Good broadcast frame
    build(BCAST, 64);
    sendFrame(0, mkExp(0, 0, 0, 0, 0, 64), 1);
    // Bit 0 of byte 20 flipped
    build(BCAST, 64);
    frm[20] = frm[20] ^ 8'h01;
    sendFrame(0, mkExp(1, 0, 0, 0, 0, 64), 1);
    // Runt with valid FCS
    build(BCAST, 63);
    sendFrame(0, mkExp(0, 1, 0, 0, 0, 63), 1);
    // Giant
    build(BCAST, 1519);
    sendFrame(0, mkExp(0, 0, 1, 0, 0, 1519), 1);
    // Idle gap on every other cycle
    build(BCAST, 64);
    sendFrame(1, mkExp(0, 0, 0, 0, 0, 64), 1);
    // Sof at byte 30 aborts, then a full good frame
    build(BCAST, 64);
    frm = frm[0:29];
    sendFrame(0, mkExp(0, 0, 0, 0, 0, 0), 0);
    pushExp(mkExp(1, 1, 0, 1, 0, 30));
    build(BCAST, 64);
    sendFrame(0, mkExp(0, 0, 0, 0, 0, 64), 1);
    // One-byte frame: Sof and Eof together
    pushExp(mkExp(1, 1, 0, 0, FILT, 1));
    driveByte(8'hFF, 1, 1);
    idle();
    // Bytes without Sof (last one a lone Eof) produce no status
    for (int i = 0; i < 4; i++) begin
      driveByte(8'(i + 8'h40), 0, i == 3);
      @(negedge Clk);
      chk("idle_no_done", rxIf.Frame_Done, 1'b0);
    end
    idle();
    // Reset at byte 10 of a frame: no status, counters cleared
    build(BCAST, 64);
    for (int i = 0; i < 10; i++) driveByte(frm[i], i == 0, 0);
    Rst = 1'b1;
    driveByte(frm[10], 0, 0);
    idle();
    mCg = 0;
    mCb = 0;
    Rst = 1'b0;
    idle();
    @(negedge Clk);
    chk("rst_mid_frame", {rxIf.Frame_Done, rxIf.Cnt_Good, rxIf.Cnt_Bad}, 33'd0);
    build(BCAST, 64);
    sendFrame(0, mkExp(0, 0, 0, 0, 0, 64), 1);
`ifdef ETH_RX_ADDR_FILT_EN
    build(48'h02_00_00_00_00_02, 64);
    sendFrame(0, mkExp(0, 0, 0, 0, 1, 64), 1);
    build(MAC, 64);
    sendFrame(0, mkExp(0, 0, 0, 0, 0, 64), 1);
`endif

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge Clk);
    if (expQ.size() != 0) chk("scoreboard_drain", 64'(expQ.size()), 64'd0);
    repeat (2) @(posedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
